c1541_sd_arb: RTL and testbench

- Round-robin arbiter that shares one SD block-I/O port (LBA, rd/wr strobe, ack, buffer write strobe) between NDRIVES c1541 track-buffer loaders (e.g. drive 8 and drive 9).
- Grants one 512-byte block command at a time, holds the LBA stable, and routes ack and buffer-write strobes only to the granted drive.
- Sits between the per-drive track loaders and the host SD interface, in the SD clock domain.

---
 rtl/c1541_sd_arb.sv | 186 ++++++++++++++++++
 tb/tb_c1541_sd_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_sd_arb.sv
// Round-robin arbiter sharing one SD block-I/O port between NDRIVES c1541 track loaders.
// Optional REQ-phase ack timeout is built when C1541_SD_ARB_TIMEOUT_EN is defined.
module c1541_sd_arb #(
    parameter int NDRIVES   = 2,
    parameter int IDXW      = 1,
    parameter int TIMEOUT_W = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NDRIVES*32-1:0] drv_lba,
    input  logic [NDRIVES-1:0]    drv_rd,
    input  logic [NDRIVES-1:0]    drv_wr,
    output logic [NDRIVES-1:0]    drv_ack,
    output logic [NDRIVES-1:0]    drv_buff_wr,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic                  sd_buff_wr,
    output logic [IDXW-1:0]       grant_idx,
    output logic                  busy,
    output logic [NDRIVES-1:0]    err
);

    if (NDRIVES < 1 || NDRIVES > 4 || IDXW < $clog2(NDRIVES) || TIMEOUT_W < 2) begin : g_bad_cfg
        $error("c1541_sd_arb: unsupported parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [31:0]       lba_q, lba_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic [NDRIVES-1:0]   req;
    logic [2*NDRIVES-1:0] req2;
    logic [NDRIVES-1:0]   rot;
    logic                 found;
    int                   pick;
    logic [31:0]          lba_sel;
    logic                 wr_sel;
    logic                 active;

`ifdef C1541_SD_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [NDRIVES-1:0]   err_q, err_d;
`endif

    assign req  = drv_rd | drv_wr;
    assign req2 = {req, req};

    // Rotate the doubled request vector so bit 0 is drive rr+1; lowest set bit wins.
    always_comb begin
        rot   = NDRIVES'(req2 >> (int'(rr_q) + 1));
        found = 1'b0;
        pick  = 0;
        for (int j = NDRIVES - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                pick  = int'(rr_q) + 1 + j;
            end
        end
        if (pick >= NDRIVES) begin
            pick = pick - NDRIVES;
        end
        lba_sel = '0;
        wr_sel  = 1'b0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (pick == i) begin
                lba_sel = drv_lba[32*i +: 32];
                wr_sel  = drv_wr[i];
            end
        end
    end

    assign active = (state_q == S_REQ) || (state_q == S_XFER);

    always_comb begin
        drv_ack     = '0;
        drv_buff_wr = '0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (active && (grant_q == IDXW'(i))) begin
                drv_ack[i]     = sd_ack;
                drv_buff_wr[i] = sd_buff_wr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef C1541_SD_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif
        case (state_q)
            // A transfer still acking after reset must drain before anything is granted.
            S_IDLE: begin
                if (!sd_ack && found) begin
                    grant_d = pick[IDXW-1:0];
                    lba_d   = lba_sel;
                    wr_d    = wr_sel;
                    rd_d    = !wr_sel;
                    state_d = S_REQ;
`ifdef C1541_SD_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_XFER;
                end
`ifdef C1541_SD_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                    if (&cnt_d) begin
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        rr_d    = grant_q;
                        state_d = S_REL;
                        for (int i = 0; i < NDRIVES; i++) begin
                            err_d[i] = (grant_q == IDXW'(i));
                        end
                    end
                end
`endif
            end
            S_XFER: begin
                if (!sd_ack) begin
                    rr_d    = grant_q;
                    state_d = S_REL;
                end
            end
            S_REL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef C1541_SD_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef C1541_SD_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign sd_lba    = lba_q;
    assign sd_rd     = rd_q;
    assign sd_wr     = wr_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q != S_IDLE);
`ifdef C1541_SD_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = '0;
`endif

endmodule

// File: tb/tb_c1541_sd_arb.sv
// Bench for c1541_sd_arb: directed vector table, corner sequences, and a random run against a transaction model.
module tb_c1541_sd_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] drv_lba;
    logic [1:0]  drv_rd, drv_wr, drv_ack, drv_buff_wr, err;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
    logic [0:0]  grant_idx;

    int errors = 0;
    int checks = 0;
    int e = 0;

    always #5 clk = ~clk;

    c1541_sd_arb #(.NDRIVES(2), .IDXW(1), .TIMEOUT_W(4)) dut (
        .clk(clk), .reset(reset), .drv_lba(drv_lba), .drv_rd(drv_rd), .drv_wr(drv_wr),
        .drv_ack(drv_ack), .drv_buff_wr(drv_buff_wr), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .grant_idx(grant_idx),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  rd, wr;
        logic [31:0] lba0, lba1;
        logic        ack, bwr;
        logic        e_rd, e_wr;
        logic [31:0] e_lba;
        logic        e_busy;
        logic        e_g;
        logic [1:0]  e_ack, e_bwr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                                input logic [31:0] l0, input logic [31:0] l1, input logic ack,
                                input logic bwr, input logic erd, input logic ewr,
                                input logic [31:0] elba, input logic ebusy, input logic eg,
                                input logic [1:0] eack, input logic [1:0] ebwr);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.lba0 = l0; v.lba1 = l1; v.ack = ack; v.bwr = bwr;
        v.e_rd = erd; v.e_wr = ewr; v.e_lba = elba; v.e_busy = ebusy; v.e_g = eg;
        v.e_ack = eack; v.e_bwr = ebwr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    // Round-robin among two drives: the other drive wins if it is pending.
    function automatic int winner(input logic [1:0] r, input int last);
        int other;
        other = (last == 0) ? 1 : 0;
        if ((other == 1) ? r[1] : r[0]) return other;
        return last;
    endfunction

    initial begin
        int n, bad, bad0, exp_g;
        logic [1:0] pre_req, pre_wr;
        logic [63:0] pre_lba;
        logic pre_ack;
        logic m_active, m_acked, m_dir;
        int m_drive, m_last, free_edge;
        logic [31:0] m_lba;
        logic [1:0] oh;
        int h_phase, h_delay, h_len;

        reset = 1'b1; drv_lba = '0; drv_rd = '0; drv_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;

        // rst rd wr lba0 lba1 ack bwr | rd wr lba busy g ack bwr
        vt.push_back(mk(1'b1, 2'b00, 2'b00, 'h0,   'h0,   1'b0, 1'b0, 1'b0, 1'b0, 'h0,   1'b0, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b00, 'h120, 'h0,   1'b0, 1'b0, 1'b1, 1'b0, 'h120, 1'b1, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b00, 'h120, 'h0,   1'b1, 1'b0, 1'b0, 1'b0, 'h120, 1'b1, 1'b0, 2'b01, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h120, 'h0,   1'b1, 1'b1, 1'b0, 1'b0, 'h120, 1'b1, 1'b0, 2'b01, 2'b01));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h120, 'h0,   1'b1, 1'b0, 1'b0, 1'b0, 'h120, 1'b1, 1'b0, 2'b01, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h120, 'h0,   1'b0, 1'b0, 1'b0, 1'b0, 'h120, 1'b1, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h120, 'h0,   1'b0, 1'b0, 1'b0, 1'b0, 'h120, 1'b0, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b11, 2'b00, 'h200, 'h300, 1'b0, 1'b0, 1'b1, 1'b0, 'h300, 1'b1, 1'b1, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b11, 2'b00, 'h200, 'h300, 1'b1, 1'b1, 1'b0, 1'b0, 'h300, 1'b1, 1'b1, 2'b10, 2'b10));
        vt.push_back(mk(1'b0, 2'b01, 2'b00, 'h200, 'h300, 1'b0, 1'b0, 1'b0, 1'b0, 'h300, 1'b1, 1'b1, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b00, 'h200, 'h300, 1'b0, 1'b0, 1'b0, 1'b0, 'h300, 1'b0, 1'b1, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b00, 'h200, 'h300, 1'b0, 1'b0, 1'b1, 1'b0, 'h200, 1'b1, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h200, 'h300, 1'b1, 1'b0, 1'b0, 1'b0, 'h200, 1'b1, 1'b0, 2'b01, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h200, 'h300, 1'b0, 1'b0, 1'b0, 1'b0, 'h200, 1'b1, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h200, 'h300, 1'b0, 1'b0, 1'b0, 1'b0, 'h200, 1'b0, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b01, 'h55,  'h0,   1'b0, 1'b0, 1'b0, 1'b1, 'h55,  1'b1, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b01, 'h55,  'h0,   1'b1, 1'b0, 1'b0, 1'b0, 'h55,  1'b1, 1'b0, 2'b01, 2'b00));
        vt.push_back(mk(1'b1, 2'b01, 2'b01, 'h55,  'h0,   1'b1, 1'b0, 1'b0, 1'b0, 'h0,   1'b0, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b00, 'h55,  'h0,   1'b1, 1'b0, 1'b0, 1'b0, 'h0,   1'b0, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b01, 2'b00, 'h55,  'h0,   1'b0, 1'b0, 1'b1, 1'b0, 'h55,  1'b1, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h99,  'h0,   1'b1, 1'b0, 1'b0, 1'b0, 'h55,  1'b1, 1'b0, 2'b01, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h99,  'h0,   1'b0, 1'b0, 1'b0, 1'b0, 'h55,  1'b1, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(1'b0, 2'b00, 2'b00, 'h99,  'h0,   1'b0, 1'b0, 1'b0, 1'b0, 'h55,  1'b0, 1'b0, 2'b00, 2'b00));

        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; drv_rd = vt[i].rd; drv_wr = vt[i].wr;
            drv_lba = {vt[i].lba1, vt[i].lba0}; sd_ack = vt[i].ack; sd_buff_wr = vt[i].bwr;
            tick();
            check($sformatf("vec%0d.sd_rd", i), 64'(sd_rd), 64'(vt[i].e_rd));
            check($sformatf("vec%0d.sd_wr", i), 64'(sd_wr), 64'(vt[i].e_wr));
            check($sformatf("vec%0d.sd_lba", i), 64'(sd_lba), 64'(vt[i].e_lba));
            check($sformatf("vec%0d.busy", i), 64'(busy), 64'(vt[i].e_busy));
            check($sformatf("vec%0d.grant", i), 64'(grant_idx), 64'(vt[i].e_g));
            check($sformatf("vec%0d.drv_ack", i), 64'(drv_ack), 64'(vt[i].e_ack));
            check($sformatf("vec%0d.drv_buff_wr", i), 64'(drv_buff_wr), 64'(vt[i].e_bwr));
            check($sformatf("vec%0d.err", i), 64'(err), 64'(0));
        end

        // Host never acks: REQ either times out or holds the strobe.
        drv_rd = 2'b01; drv_lba = {32'h0, 32'h77};
        tick();
        check("noack.first", 64'({sd_rd, sd_lba}), 64'({1'b1, 32'h77}));
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (sd_rd !== 1'b1) bad++;
        end
        check("noack.hold14", 64'(bad), 64'(0));
`ifdef C1541_SD_ARB_TIMEOUT_EN
        drv_rd = 2'b00;
        tick();
        check("timeout.sd_rd", 64'(sd_rd), 64'(0));
        check("timeout.err", 64'(err), 64'(2'b01));
        tick();
        check("timeout.err_clear", 64'(err), 64'(0));
        check("timeout.idle", 64'(busy), 64'(0));
`else
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (sd_rd !== 1'b1 || err !== 2'b00) bad++;
        end
        check("noack.hold_forever", 64'(bad), 64'(0));
        drv_rd = 2'b00; sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        tick();
        check("noack.idle", 64'(busy), 64'(0));
`endif

        // Streaming: both drives always pending, grants must alternate starting at drive 1.
        reset = 1'b1; tick(); reset = 1'b0;
        drv_rd = 2'b11; drv_lba = {32'h1000, 32'h2000};
        for (int k = 0; k < 32; k++) begin
            n = 0;
            while (!sd_rd && n < 10) begin
                tick();
                n++;
            end
            check($sformatf("stream%0d.wait", k), 64'(sd_rd && n <= 3), 64'(1));
            exp_g = (k % 2 == 0) ? 1 : 0;
            check($sformatf("stream%0d.grant", k), 64'(grant_idx), 64'(exp_g));
            check($sformatf("stream%0d.lba", k), 64'(sd_lba), (exp_g == 1) ? 64'h1000 : 64'h2000);
            sd_ack = 1'b1;
            tick();
            tick();
            sd_ack = 1'b0;
        end
        drv_rd = 2'b00;
        tick(); tick(); tick();

        // Buffer steering during a drive-1 write.
        drv_wr = 2'b10; drv_lba = {32'hABC, 32'h0};
        n = 0;
        while (!sd_wr && n < 10) begin
            tick();
            n++;
        end
        check("buf.grant", 64'({sd_wr, sd_rd, grant_idx}), 64'({1'b1, 1'b0, 1'b1}));
        drv_wr = 2'b00; sd_ack = 1'b1;
        bad = 0; bad0 = 0;
        for (int k = 0; k < 512; k++) begin
            sd_buff_wr = 1'b1;
            tick();
            if (drv_buff_wr !== 2'b10) bad++;
            if (drv_buff_wr[0] !== 1'b0) bad0++;
            sd_buff_wr = 1'b0;
            tick();
            if (drv_buff_wr !== 2'b00) bad++;
        end
        check("buf.steer", 64'(bad), 64'(0));
        check("buf.drive0_clear", 64'(bad0), 64'(0));
        sd_ack = 1'b0;
        tick(); tick();

        // Random traffic against a transaction-level model.
        reset = 1'b1; drv_rd = '0; drv_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        tick();
        reset = 1'b0;
        m_active = 1'b0; m_acked = 1'b0; m_dir = 1'b0; m_drive = 0; m_last = 0;
        m_lba = '0; free_edge = e + 1; h_phase = 0; h_delay = 0; h_len = 0;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) drv_rd = 2'($urandom);
            if ($urandom_range(0, 3) == 0) drv_wr = 2'($urandom) & 2'($urandom);
            if ($urandom_range(0, 4) == 0) drv_lba = {32'($urandom), 32'($urandom)};
            if (h_phase == 3 && !m_active) h_phase = 0;
            if (m_active && h_phase == 0) begin
                h_phase = 1; h_delay = $urandom_range(0, 3); h_len = $urandom_range(1, 4);
            end
            if (h_phase == 1) begin
                if (h_delay == 0) h_phase = 2;
                else h_delay--;
            end
            if (h_phase == 2) begin
                if (h_len > 0) begin
                    sd_ack = 1'b1;
                    h_len--;
                end else begin
                    sd_ack = 1'b0;
                    h_phase = 3;
                end
            end
            sd_buff_wr = sd_ack & 1'($urandom);
            pre_req = drv_rd | drv_wr; pre_wr = drv_wr; pre_lba = drv_lba; pre_ack = sd_ack;
            tick();
            if (!m_active) begin
                if (e >= free_edge && !pre_ack && pre_req != 2'b00) begin
                    m_drive = winner(pre_req, m_last);
                    m_dir = (m_drive == 1) ? pre_wr[1] : pre_wr[0];
                    m_lba = (m_drive == 1) ? pre_lba[63:32] : pre_lba[31:0];
                    m_active = 1'b1; m_acked = 1'b0;
                end
            end else if (pre_ack) begin
                m_acked = 1'b1;
            end else if (m_acked) begin
                m_active = 1'b0; m_last = m_drive; free_edge = e + 2;
            end
            oh = (m_drive == 1) ? 2'b10 : 2'b01;
            if (sd_rd !== (m_active && !m_acked && !m_dir)) bad++;
            if (sd_wr !== (m_active && !m_acked && m_dir)) bad++;
            if (sd_lba !== m_lba) bad++;
            if (grant_idx !== 1'(m_drive)) bad++;
            if (busy !== (m_active || e < free_edge - 1)) bad++;
            if (drv_ack !== (m_active ? (oh & {2{sd_ack}}) : 2'b00)) bad++;
            if (drv_buff_wr !== (m_active ? (oh & {2{sd_buff_wr}}) : 2'b00)) bad++;
            if (err !== 2'b00) bad++;
            if (bad != 0 && c < 3000) begin
                check($sformatf("rand.cycle%0d", c), 64'(bad), 64'(0));
                bad = 0;
            end
        end
        check("rand.total", 64'(bad), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
